// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable divider controller.
package clk_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PEND} div_state_e;

   localparam int unsigned MIN_DIV = 2;

   function automatic logic is_valid_div(input int unsigned v);
      return v >= MIN_DIV;
   endfunction

endpackage

// File: rtl/clk_div_if.sv
// Ratio-update handshake between a requester (master) and the divider controller (slave).
interface clk_div_if #(parameter int CNT_W = 8);

   logic             div_req_i;
   logic [CNT_W-1:0] div_val_i;
   logic             div_ack_o;
   logic             err_o;

   modport master (output div_req_i, div_val_i, input div_ack_o, err_o);
   modport slave  (input div_req_i, div_val_i, output div_ack_o, err_o);

endinterface

// File: rtl/clk_div_core.sv
// Down-counter with load strobe, reload-at-zero and terminal-count flag.
// The next-count output exists only when DIV_DUTY50_EN is defined.
module clk_div_core #(
   parameter int CNT_W   = 8,
   parameter int RST_VAL = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
`ifdef DIV_DUTY50_EN
   output logic [CNT_W-1:0] cnt_nxt,
`endif
   output logic             tc
);

   logic [CNT_W-1:0] cnt_d;

   assign tc = (cnt == '0);

   // Reload at zero instead of wrapping so every period is exactly load_val+1 cycles.
   always_comb begin
      cnt_d = cnt;
      if (load)
         cnt_d = load_val;
      else if (run)
         cnt_d = tc ? load_val : cnt - CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt <= CNT_W'(RST_VAL);
      else       cnt <= cnt_d;
   end

`ifdef DIV_DUTY50_EN
   assign cnt_nxt = cnt_d;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: FSM, ratio handshake and active ratio around clk_div_core.
// Define DIV_DUTY50_EN to add the registered 50%-duty div_clk_o output.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   clk_div_if.slave         bus,
   output logic             tick_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             busy_o
`ifdef DIV_DUTY50_EN
   , output logic           div_clk_o
`endif
);

   div_state_e       state, state_d;
   logic [CNT_W-1:0] div_active, div_d;
   logic [CNT_W-1:0] pend_div, pend_d;
   logic             ack_q, ack_d, err_q, err_d;
   logic             tc, stopping, req_take, req_ok, pend_ack;

   // Dropping en_i wins over everything, so a low en_i behaves like IDLE this cycle.
   assign stopping = (state == IDLE) || !en_i;
   assign pend_ack = (state == PEND) && tc && en_i;
   assign tick_o   = (state != IDLE) && tc && en_i;
   assign busy_o   = (state != IDLE);

   assign bus.div_ack_o = ack_q || pend_ack;
   assign bus.err_o     = err_q;

   // The request is consumed in its ack cycle and held while PEND waits for the terminal count.
   assign req_take = bus.div_req_i && !bus.div_ack_o && (state != PEND);
   assign req_ok   = is_valid_div(32'(bus.div_val_i));

   always_comb begin
      state_d = state;
      div_d   = div_active;
      pend_d  = pend_div;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: if (en_i) state_d = RUN;
         RUN: begin
            if (!en_i) state_d = IDLE;
            else if (req_take && req_ok) begin
               state_d = PEND;
               pend_d  = bus.div_val_i;
            end
         end
         PEND: begin
            if (!en_i) begin
               state_d = IDLE;
               div_d   = pend_div;
               ack_d   = 1'b1;
            end else if (tc) begin
               state_d = RUN;
               div_d   = pend_div;
            end
         end
         default: state_d = IDLE;
      endcase
      if (req_take) begin
         if (!req_ok) begin
            ack_d = 1'b1;
            err_d = 1'b1;
         end else if (stopping) begin
            div_d = bus.div_val_i;
            ack_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         div_active <= CNT_W'(DEFAULT_DIV);
         pend_div   <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_d;
         div_active <= div_d;
         pend_div   <= pend_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

`ifdef DIV_DUTY50_EN
   logic [CNT_W-1:0] cnt_nxt;
   logic             div_clk_q;
`endif

   clk_div_core #(.CNT_W(CNT_W), .RST_VAL(DEFAULT_DIV - 1)) u_core (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run      (!stopping),
      .load     (stopping),
      .load_val (div_d - CNT_W'(1)),
      .cnt      (cnt_o),
`ifdef DIV_DUTY50_EN
      .cnt_nxt  (cnt_nxt),
`endif
      .tc       (tc)
   );

`ifdef DIV_DUTY50_EN
   // Registered from next-cycle count/ratio so it lines up with cnt_o: high for the top ceil(N/2) counts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) div_clk_q <= 1'b0;
      else       div_clk_q <= (state_d != IDLE) && (cnt_nxt >= (div_d >> 1));
   end
   assign div_clk_o = div_clk_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a phase-based reference model predicts each cycle's outputs.
module tb_clk_div_ctrl;

   localparam int CNT_W = 8;
   localparam int DEF   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic             tick, busy;
   logic [CNT_W-1:0] cnt;
`ifdef DIV_DUTY50_EN
   logic             dclk;
`endif

   clk_div_if #(.CNT_W(CNT_W)) bus ();

   clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .bus       (bus),
      .tick_o    (tick),
      .cnt_o     (cnt),
      .busy_o    (busy)
`ifdef DIV_DUTY50_EN
      , .div_clk_o (dclk)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      bit tick, ack, err, busy, dclk;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   mon_on = 1'b0;

   // Model: running flag, active ratio, cycles elapsed in the current period, pending ratio.
   bit m_run, m_pend, m_ackq, m_errq, last_ack;
   int m_n, m_k, m_pn;

   task automatic chk(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   function automatic void m_reset();
      m_run = 0; m_pend = 0; m_ackq = 0; m_errq = 0;
      m_n = DEF; m_k = 0; m_pn = 0;
   endfunction

   task automatic cycle(bit e, bit r, int v);
      exp_t x;
      bit   take, was;
      @(posedge clk); #1;
      rst = 1'b0; en = e; bus.div_req_i = r; bus.div_val_i = v[CNT_W-1:0];
      x.cnt  = m_n - 1 - m_k;
      x.busy = m_run;
      x.tick = m_run && e && (m_k == m_n - 1);
      x.ack  = m_ackq || (m_pend && e && (m_k == m_n - 1));
      x.err  = m_errq;
      x.dclk = m_run && (x.cnt >= m_n / 2);
      exp_q.push_back(x);
      mon_on   = 1'b1;
      last_ack = x.ack;
      take = r && !x.ack && !m_pend;
      was  = m_run;
      m_ackq = 0; m_errq = 0;
      if (!e) begin
         if (m_pend) begin m_n = m_pn; m_pend = 0; m_ackq = 1; end
         m_run = 0; m_k = 0;
      end else if (!m_run) begin
         m_run = 1; m_k = 0;
      end else if (m_k == m_n - 1) begin
         m_k = 0;
         if (m_pend) begin m_n = m_pn; m_pend = 0; end
      end else m_k++;
      if (take) begin
         if (v < 2) begin m_ackq = 1; m_errq = 1; end
         else if (!e || !was) begin m_n = v; m_k = 0; m_ackq = 1; end
         else begin m_pend = 1; m_pn = v; end
      end
   endtask

   task automatic run_cycles(int n, bit e);
      repeat (n) cycle(e, 1'b0, 0);
   endtask

   task automatic request(bit e, int v);
      for (int i = 0; i < 600; i++) begin
         cycle(e, 1'b1, v);
         if (last_ack) break;
      end
   endtask

   task automatic wait_cnt(int c);
      for (int i = 0; i < 600 && (m_n - 1 - m_k) != c; i++) cycle(1'b1, 1'b0, 0);
   endtask

   task automatic do_reset();
      exp_t x;
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; bus.div_req_i = 1'b0;
      #1;
      chk("rst_cnt", int'(cnt), DEF - 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_ack", int'(bus.div_ack_o), 0);
      m_reset();
      x.cnt = DEF - 1; x.tick = 0; x.ack = 0; x.err = 0; x.busy = 0; x.dclk = 0;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (mon_on) begin
         cyc++;
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty cycle=%0d actual=0 entries required=1", cyc);
         end else begin
            x = exp_q.pop_front();
            chk("cnt", int'(cnt), x.cnt);
            chk("tick", int'(tick), int'(x.tick));
            chk("ack", int'(bus.div_ack_o), int'(x.ack));
            chk("err", int'(bus.err_o), int'(x.err));
            chk("busy", int'(busy), int'(x.busy));
`ifdef DIV_DUTY50_EN
            chk("div_clk", int'(dclk), int'(x.dclk));
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, v;
      bus.div_req_i = 1'b0;
      bus.div_val_i = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_cnt", int'(cnt), DEF - 1);
      chk("init_busy", int'(busy), 0);
      chk("init_tick", int'(tick), 0);
      chk("init_err", int'(bus.err_o), 0);

      run_cycles(12, 1'b1);                          // default N=4
      wait_cnt(2); request(1'b1, 6); run_cycles(14, 1'b1);
      request(1'b1, 4); run_cycles(10, 1'b1);
      request(1'b1, 1); request(1'b1, 0); run_cycles(8, 1'b1);
      wait_cnt(1); run_cycles(3, 1'b0); run_cycles(10, 1'b1);
      wait_cnt(2); cycle(1'b1, 1'b1, 8); cycle(1'b1, 1'b1, 8);
      do_reset(); run_cycles(10, 1'b1);
      run_cycles(2, 1'b0); request(1'b0, 5); run_cycles(12, 1'b1);
      cycle(1'b1, 1'b1, 7); request(1'b0, 7); run_cycles(16, 1'b1);
      wait_cnt(0); run_cycles(2, 1'b0); run_cycles(6, 1'b1);
      request(1'b1, 255); run_cycles(520, 1'b1);
      request(1'b1, 3); run_cycles(8, 1'b1);

      for (int it = 0; it < 60; it++) begin
         a = int'($urandom_range(0, 9));
         v = int'($urandom_range(2, 9));
         if (a < 4)       run_cycles(int'($urandom_range(1, 12)), ($urandom_range(0, 4) != 0));
         else if (a < 7)  request(1'b1, v);
         else if (a == 7) request(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         else if (a == 8) begin cycle(1'b1, 1'b1, v); request(1'b0, v); end
         else             do_reset();
      end
      run_cycles(4, 1'b1);

      @(negedge clk); #1;
      mon_on = 1'b0;
      chk("queue_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
